// File: rtl/rgb2ycocg_pkg.sv
// rgb2ycocg_pkg: shared constants, pixel types and maxPoint legality check for the encoder colour path
package rgb2ycocg_pkg;
    localparam int MAXPOINT_8B  = 255;
    localparam int MAXPOINT_10B = 1023;
    localparam int MAXPOINT_12B = 4095;
    localparam int BLK_PIXELS   = 16;
    localparam int CNT_W        = $clog2(BLK_PIXELS);
    localparam int PIX_W        = 12;
    localparam int SPIX_W       = 14;
    typedef logic [PIX_W-1:0] pix_t;
    typedef logic signed [SPIX_W-1:0] spix_t;
    function automatic logic mp_legal(input logic [12:0] mp);
        return mp == 13'(MAXPOINT_8B) || mp == 13'(MAXPOINT_10B) || mp == 13'(MAXPOINT_12B);
    endfunction
endpackage

// File: rtl/rgb2ycocg_if.sv
// rgb2ycocg_if: source pixel stream in, YCoCg pixel stream out, both with valid/ready
interface rgb2ycocg_if;
    import rgb2ycocg_pkg::*;
    logic             in_valid;
    logic             in_ready;
    pix_t             src_r;
    pix_t             src_g;
    pix_t             src_b;
    logic             out_valid;
    logic             out_ready;
    spix_t            dst_y;
    spix_t            dst_co;
    spix_t            dst_cg;
    logic [CNT_W-1:0] out_pos;
    logic             out_last;
    modport master (
        output in_valid, src_r, src_g, src_b, out_ready,
        input  in_ready, out_valid, dst_y, dst_co, dst_cg, out_pos, out_last
    );
    modport slave (
        input  in_valid, src_r, src_g, src_b, out_ready,
        output in_ready, out_valid, dst_y, dst_co, dst_cg, out_pos, out_last
    );
endinterface

// File: rtl/rgb2ycocg_core.sv
// rgb2ycocg_core: combinational YCoCg-R lifting pair; first step from R/B, second step from registered G/t
module rgb2ycocg_core
    import rgb2ycocg_pkg::*;
(
    input  pix_t  r,
    input  pix_t  b,
    input  pix_t  g,
    input  spix_t t_in,
    output spix_t co,
    output spix_t t,
    output spix_t cg,
    output spix_t y
);
    assign co = $signed({2'b00, r}) - $signed({2'b00, b});
    assign t  = $signed({2'b00, b}) + (co >>> 1);
    assign cg = $signed({2'b00, g}) - t_in;
    assign y  = t_in + (cg >>> 1);
endmodule

// File: rtl/rgb2ycocg_pipe.sv
// rgb2ycocg_pipe: two-stage RGB to YCoCg-R pipeline with backpressure, block position and sticky error flags
module rgb2ycocg_pipe #(
    parameter int BLK_PIXELS = rgb2ycocg_pkg::BLK_PIXELS,
    parameter int CNT_W      = rgb2ycocg_pkg::CNT_W
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [12:0] maxPoint,
    input  logic        clear,
    rgb2ycocg_if.slave  p,
    output logic        range_err,
    output logic        cfg_err
);
    import rgb2ycocg_pkg::*;
    logic             legal, over, s1_valid, s1_bad, s1_load, s2_load;
    pix_t             r_c, g_c, b_c, s1_g;
    spix_t            co, t, cg, y, s1_co, s1_t;
    logic [CNT_W-1:0] cnt;
    always_comb begin
        legal      = mp_legal(maxPoint);
        over       = {1'b0, p.src_r} > maxPoint || {1'b0, p.src_g} > maxPoint || {1'b0, p.src_b} > maxPoint;
        r_c        = {1'b0, p.src_r} > maxPoint ? pix_t'(maxPoint) : p.src_r;
        g_c        = {1'b0, p.src_g} > maxPoint ? pix_t'(maxPoint) : p.src_g;
        b_c        = {1'b0, p.src_b} > maxPoint ? pix_t'(maxPoint) : p.src_b;
        s2_load    = s1_valid && (!p.out_valid || p.out_ready);
        p.in_ready = !clear && (!s1_valid || s2_load);
        s1_load    = p.in_valid && p.in_ready;
        p.out_pos  = cnt;
        p.out_last = cnt == CNT_W'(BLK_PIXELS - 1);
    end
    rgb2ycocg_core u_core (
        .r(r_c), .b(b_c), .g(s1_g), .t_in(s1_t),
        .co(co), .t(t), .cg(cg), .y(y)
    );
    // clear flushes both stages and the counter but leaves the sticky flags alone
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid    <= 1'b0;
            s1_bad      <= 1'b0;
            s1_g        <= '0;
            s1_co       <= '0;
            s1_t        <= '0;
            p.out_valid <= 1'b0;
            p.dst_y     <= '0;
            p.dst_co    <= '0;
            p.dst_cg    <= '0;
            cnt         <= '0;
            range_err   <= 1'b0;
            cfg_err     <= 1'b0;
        end else if (clear) begin
            s1_valid    <= 1'b0;
            p.out_valid <= 1'b0;
            cnt         <= '0;
        end else begin
            s1_valid    <= s1_load || (s1_valid && !s2_load);
            p.out_valid <= s2_load || (p.out_valid && !p.out_ready);
            if (s1_load) begin
                s1_g      <= g_c;
                s1_co     <= co;
                s1_t      <= t;
                s1_bad    <= !legal;
                range_err <= range_err | over;
                cfg_err   <= cfg_err | !legal;
            end
            if (s2_load) begin
                p.dst_y  <= s1_bad ? '0 : y;
                p.dst_co <= s1_bad ? '0 : s1_co;
                p.dst_cg <= s1_bad ? '0 : cg;
            end
            if (p.out_valid && p.out_ready)
                cnt <= cnt == CNT_W'(BLK_PIXELS - 1) ? '0 : cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_rgb2ycocg_pipe.sv
// tb_rgb2ycocg_pipe: scoreboard bench with an arithmetic YCoCg-R reference and inverse-transform round trip
module tb_rgb2ycocg_pipe;
    import rgb2ycocg_pkg::*;
    typedef struct {
        int y, co, cg, r, g, b;
        bit bad;
    } exp_t;
    logic        clk = 1'b0, rst_n = 1'b0, clear = 1'b0;
    logic [12:0] maxPoint = 13'd255;
    logic        range_err, cfg_err;
    rgb2ycocg_if bus();
    rgb2ycocg_pipe dut (
        .clk(clk), .rst_n(rst_n), .maxPoint(maxPoint), .clear(clear),
        .p(bus), .range_err(range_err), .cfg_err(cfg_err)
    );
    always #5 clk = ~clk;
    exp_t q[$];
    int   n_chk = 0, n_pass = 0, exp_pos = 0, n_out = 0, n_last = 0;
    bit   exp_range = 0, exp_cfg = 0, pend_range = 0, pend_cfg = 0;
    bit   prev_clr = 0, prev_rst = 0, acc = 0;

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    function automatic int half(input int x);
        return x >= 0 ? x / 2 : -((1 - x) / 2);
    endfunction

    function automatic exp_t model(input int r, input int g, input int b, input int mp);
        exp_t e;
        int   t;
        e.r   = r > mp ? mp : r;
        e.g   = g > mp ? mp : g;
        e.b   = b > mp ? mp : b;
        e.bad = !(mp == 255 || mp == 1023 || mp == 4095);
        e.co  = e.r - e.b;
        t     = e.b + half(e.co);
        e.cg  = e.g - t;
        e.y   = t + half(e.cg);
        if (e.bad) begin
            e.y  = 0;
            e.co = 0;
            e.cg = 0;
        end
        return e;
    endfunction

    task automatic cyc(input bit v, input int r, input int g, input int b,
                       input bit ord, input bit clr, input bit rst);
        @(negedge clk);
        exp_range  = exp_range | pend_range;
        exp_cfg    = exp_cfg | pend_cfg;
        pend_range = 0;
        pend_cfg   = 0;
        if (prev_rst) begin
            q.delete();
            exp_pos   = 0;
            exp_range = 0;
            exp_cfg   = 0;
            check("rst_out_valid", int'(bus.out_valid), 0);
            check("rst_dst_y", int'(bus.dst_y), 0);
            check("rst_dst_co", int'(bus.dst_co), 0);
            check("rst_dst_cg", int'(bus.dst_cg), 0);
            check("rst_out_pos", int'(bus.out_pos), 0);
            check("rst_out_last", int'(bus.out_last), 0);
            check("rst_range_err", int'(range_err), 0);
            check("rst_cfg_err", int'(cfg_err), 0);
        end else if (prev_clr) begin
            q.delete();
            exp_pos = 0;
            check("clr_out_valid", int'(bus.out_valid), 0);
            check("clr_out_pos", int'(bus.out_pos), 0);
        end
        prev_rst      = rst;
        prev_clr      = clr && !rst;
        rst_n         = !rst;
        clear         = clr;
        bus.in_valid  = v;
        bus.src_r     = 12'(r);
        bus.src_g     = 12'(g);
        bus.src_b     = 12'(b);
        bus.out_ready = ord;
        acc           = 0;
        #1;
        if (clr && !rst) check("clr_in_ready", int'(bus.in_ready), 0);
        if (!rst && !clr && v && bus.in_ready) begin
            exp_t e;
            e = model(r, g, b, int'(maxPoint));
            q.push_back(e);
            pend_range = r > int'(maxPoint) || g > int'(maxPoint) || b > int'(maxPoint);
            pend_cfg   = e.bad;
            acc        = 1;
        end
    endtask

    task automatic idle(input bit ord);
        cyc(0, 0, 0, 0, ord, 0, 0);
    endtask

    task automatic send(input int r, input int g, input int b, input bit rnd);
        int k = 0;
        acc = 0;
        while (!acc && k < 50) begin
            cyc(1, r, g, b, rnd ? 1'($urandom_range(0, 1)) : 1'b1, 0, 0);
            k++;
        end
        if (!acc) check("send_accept", int'(acc), 1);
    endtask

    task automatic drain();
        for (int k = 0; k < 60 && q.size() != 0; k++) idle(1);
        check("drain_empty", q.size(), 0);
        idle(1);
    endtask

    // every cycle the output register must hold the oldest outstanding pixel, stalled or not
    initial forever begin
        @(negedge clk);
        #2;
        if (rst_n && bus.out_valid) begin
            if (q.size() == 0) check("out_valid_no_pixel", int'(bus.out_valid), 0);
            else begin
                int t, rg, rb, rr;
                check("dst_y", int'(bus.dst_y), q[0].y);
                check("dst_co", int'(bus.dst_co), q[0].co);
                check("dst_cg", int'(bus.dst_cg), q[0].cg);
                check("out_pos", int'(bus.out_pos), exp_pos);
                check("out_last", int'(bus.out_last), int'(exp_pos == BLK_PIXELS - 1));
                if (!q[0].bad) begin
                    t  = int'(bus.dst_y) - half(int'(bus.dst_cg));
                    rg = int'(bus.dst_cg) + t;
                    rb = t - half(int'(bus.dst_co));
                    rr = rb + int'(bus.dst_co);
                    check("roundtrip_r", rr, q[0].r);
                    check("roundtrip_g", rg, q[0].g);
                    check("roundtrip_b", rb, q[0].b);
                end
                if (bus.out_ready && !clear) begin
                    if (bus.out_last) n_last++;
                    void'(q.pop_front());
                    exp_pos = (exp_pos + 1) % BLK_PIXELS;
                    n_out++;
                end
            end
        end
        check("range_err", int'(range_err), int'(exp_range));
        check("cfg_err", int'(cfg_err), int'(exp_cfg));
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_chk);
        $fatal(1);
    end

    initial begin
        int n0, l0;
        bus.in_valid  = 0;
        bus.src_r     = '0;
        bus.src_g     = '0;
        bus.src_b     = '0;
        bus.out_ready = 0;
        repeat (3) cyc(0, 0, 0, 0, 1, 0, 1);
        idle(1);
        check("in_ready_after_rst", int'(bus.in_ready), 1);
        send(100, 100, 100, 0);
        idle(1);
        check("latency_c1_out_valid", int'(bus.out_valid), 0);
        idle(1);
        check("latency_c2_out_valid", int'(bus.out_valid), 1);
        drain();
        send(255, 0, 0, 0);
        send(0, 255, 0, 0);
        drain();
        maxPoint = 13'd4095;
        send(0, 0, 4095, 0);
        for (int i = 0; i < 20; i++)
            send(int'($urandom_range(0, 4095)), int'($urandom_range(0, 4095)), int'($urandom_range(0, 4095)), 0);
        drain();
        cyc(0, 0, 0, 0, 1, 1, 0);
        idle(1);
        n0 = n_out;
        l0 = n_last;
        for (int i = 0; i < 40; i++)
            send(int'($urandom_range(0, 4095)), int'($urandom_range(0, 4095)), int'($urandom_range(0, 4095)), 1);
        drain();
        check("burst_count", n_out - n0, 40);
        check("burst_last_count", n_last - l0, 2);
        maxPoint = 13'd1023;
        send(100, 1500, 200, 0);
        drain();
        maxPoint = 13'd500;
        send(10, 20, 30, 0);
        drain();
        maxPoint = 13'd255;
        cyc(1, 1, 2, 3, 0, 0, 0);
        cyc(1, 4, 5, 6, 0, 0, 0);
        cyc(1, 7, 8, 9, 1, 1, 0);
        idle(1);
        send(40, 50, 60, 0);
        drain();
        send(11, 22, 33, 0);
        send(44, 55, 66, 0);
        cyc(1, 77, 88, 99, 1, 0, 1);
        idle(1);
        check("rst_queue_flushed", int'(bus.out_valid), 0);
        send(200, 100, 50, 0);
        drain();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
